// File: rtl/sprite_frame_sequencer_pkg.sv
// Shared encodings for the sprite frame sequencer and other slow_clk consumers.
package sprite_frame_sequencer_pkg;
  localparam int DEF_IDX_W       = 4;
  localparam int DEF_FRAME_WORDS = 256;

  localparam logic [1:0] MODE_LOOP     = 2'b00;
  localparam logic [1:0] MODE_PINGPONG = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_REV  = 2'd2;
endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: one-cycle pulse per rising edge of a clk-synchronous level.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);
  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
endmodule

// File: rtl/sprite_frame_sequencer.sv
// Steps a sprite animation on each slow_clk rising edge; the renderer-visible frame
// index and ROM base are only updated during vertical blanking to avoid tearing.
module sprite_frame_sequencer
  import sprite_frame_sequencer_pkg::*;
#(
  parameter int IDX_W       = DEF_IDX_W,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int ADDR_W      = 12,
  parameter int HOLD_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slow_clk,
  input  logic              vblank,
  input  logic              play,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [IDX_W-1:0]  first_frame,
  input  logic [IDX_W-1:0]  last_frame,
  input  logic [HOLD_W-1:0] hold,
  output logic [IDX_W-1:0]  frame_idx,
  output logic [ADDR_W-1:0] frame_base,
  output logic              busy,
  output logic              done
);
  localparam int SH = $clog2(FRAME_WORDS);

  logic              tick;
  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [IDX_W-1:0]  first_q, first_d, last_q, last_d, next_q, next_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_cnt_q, hold_cnt_d;
  logic              done_q, done_d;
  logic [IDX_W-1:0]  frame_idx_q;
  logic [ADDR_W-1:0] frame_base_q, base_d;

  rise_detect u_rise (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (slow_clk),
    .rise_o (tick)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    first_d    = first_q;
    last_d     = last_q;
    hold_d     = hold_q;
    next_d     = next_q;
    hold_cnt_d = hold_cnt_q;
    done_d     = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (play) begin
            // Reserved mode 11 collapses to LOOP at latch time.
            mode_d     = (mode == 2'b11) ? MODE_LOOP : mode;
            first_d    = first_frame;
            last_d     = (first_frame > last_frame) ? first_frame : last_frame;
            hold_d     = hold;
            next_d     = first_frame;
            hold_cnt_d = '0;
            state_d    = ST_FWD;
          end
        end
        ST_FWD, ST_REV: begin
          if (tick) begin
            if (hold_cnt_q < hold_q) begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end else begin
              hold_cnt_d = '0;
              case (mode_q)
                MODE_PINGPONG: begin
                  if (state_q == ST_FWD) begin
                    if (next_q == last_q) begin
                      if (first_q != last_q) begin
                        next_d  = next_q - 1'b1;
                        state_d = ST_REV;
                      end
                    end else begin
                      next_d = next_q + 1'b1;
                    end
                  end else begin
                    if (next_q == first_q) begin
                      if (first_q != last_q) begin
                        next_d  = next_q + 1'b1;
                        state_d = ST_FWD;
                      end
                    end else begin
                      next_d = next_q - 1'b1;
                    end
                  end
                end
                MODE_ONESHOT: begin
                  if (next_q == last_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                  end else begin
                    next_d = next_q + 1'b1;
                  end
                end
                default: next_d = (next_q == last_q) ? first_q : next_q + 1'b1;
              endcase
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign base_d = ADDR_W'(next_q) << SH;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_LOOP;
      first_q      <= '0;
      last_q       <= '0;
      hold_q       <= '0;
      next_q       <= '0;
      hold_cnt_q   <= '0;
      done_q       <= 1'b0;
      frame_idx_q  <= '0;
      frame_base_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      first_q    <= first_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      next_q     <= next_d;
      hold_cnt_q <= hold_cnt_d;
      done_q     <= done_d;
      if (vblank) begin
        frame_idx_q  <= next_q;
        frame_base_q <= base_d;
      end
    end
  end

  assign frame_idx  = frame_idx_q;
  assign frame_base = frame_base_q;
  assign busy       = (state_q == ST_FWD) || (state_q == ST_REV);
  assign done       = done_q;
endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// Directed bench for sprite_frame_sequencer with hand-computed frame sequences.
module tb_sprite_frame_sequencer;
  logic        clk = 1'b0;
  logic        rst, slow_clk, vblank, play, stop;
  logic [1:0]  mode;
  logic [3:0]  first_frame, last_frame, hold;
  logic [3:0]  frame_idx;
  logic [11:0] frame_base;
  logic        busy, done;
  int          n_chk = 0;
  int          n_err = 0;

  sprite_frame_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .slow_clk    (slow_clk),
    .vblank      (vblank),
    .play        (play),
    .stop        (stop),
    .mode        (mode),
    .first_frame (first_frame),
    .last_frame  (last_frame),
    .hold        (hold),
    .frame_idx   (frame_idx),
    .frame_base  (frame_base),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clk; outputs are stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    slow_clk = 1'b1; step(); step();
    slow_clk = 1'b0; step(); step();
  endtask

  task automatic start(input logic [1:0] m, input logic [3:0] f, input logic [3:0] l,
                       input logic [3:0] h);
    mode = m; first_frame = f; last_frame = l; hold = h;
    play = 1'b1; step();
    play = 1'b0; step();
  endtask

  task automatic halt();
    stop = 1'b1; step();
    stop = 1'b0;
  endtask

  logic [3:0] exp_seq[];

  initial begin
    rst = 1'b1; slow_clk = 1'b0; vblank = 1'b0; play = 1'b0; stop = 1'b0;
    mode = 2'b00; first_frame = '0; last_frame = '0; hold = '0;
    step(); step();
    chk("rst_idx", frame_idx, 0);
    chk("rst_base", frame_base, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0; vblank = 1'b1; step();

    // LOOP 2..4
    start(2'b00, 4'd2, 4'd4, 4'd0);
    chk("loop_idx0", frame_idx, 2);
    chk("loop_base0", frame_base, 512);
    chk("loop_busy0", busy, 1);
    exp_seq = '{4'd3, 4'd4, 4'd2, 4'd3};
    foreach (exp_seq[i]) begin
      tick();
      chk("loop_idx", frame_idx, exp_seq[i]);
      chk("loop_base", frame_base, 32'(exp_seq[i]) * 256);
      chk("loop_busy", busy, 1);
    end

    // stop mid-LOOP freezes frame
    halt();
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    tick();
    chk("stop_idx", frame_idx, 3);

    // PINGPONG 0..2
    start(2'b01, 4'd0, 4'd2, 4'd0);
    chk("pp_idx0", frame_idx, 0);
    exp_seq = '{4'd1, 4'd2, 4'd1, 4'd0, 4'd1};
    foreach (exp_seq[i]) begin
      tick();
      chk("pp_idx", frame_idx, exp_seq[i]);
    end
    halt();

    // PINGPONG single frame
    start(2'b01, 4'd5, 4'd5, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pp1_idx", frame_idx, 5);
      chk("pp1_busy", busy, 1);
    end
    halt();

    // first > last collapses to single frame
    start(2'b00, 4'd6, 4'd3, 4'd0);
    tick();
    chk("inv_idx", frame_idx, 6);
    halt();

    // ONESHOT 1..3 hold=1
    start(2'b10, 4'd1, 4'd3, 4'd1);
    chk("os_idx0", frame_idx, 1);
    exp_seq = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd3};
    foreach (exp_seq[i]) begin
      tick();
      chk("os_idx", frame_idx, exp_seq[i]);
      chk("os_done_low", done, 0);
    end
    slow_clk = 1'b1; step();
    chk("os_done", done, 1);
    chk("os_busy", busy, 0);
    step();
    chk("os_done_pulse", done, 0);
    chk("os_idx_end", frame_idx, 3);
    slow_clk = 1'b0; step(); step();

    // vblank gating, LOOP 0..3
    vblank = 1'b0;
    start(2'b00, 4'd0, 4'd3, 4'd0);
    chk("vb_hold0", frame_idx, 3);
    tick();
    chk("vb_hold1", frame_idx, 3);
    vblank = 1'b1;
    chk("vb_pre", frame_idx, 3);
    step();
    vblank = 1'b0;
    chk("vb_commit", frame_idx, 1);
    chk("vb_base", frame_base, 256);
    tick();
    chk("vb_hold2", frame_idx, 1);

    // play while busy is ignored (next_idx now 2)
    mode = 2'b01; first_frame = 4'd7; last_frame = 4'd9;
    play = 1'b1; step(); play = 1'b0;
    vblank = 1'b1;
    tick();
    chk("pb_idx3", frame_idx, 3);
    tick();
    chk("pb_wrap", frame_idx, 0);

    // play+stop together from IDLE
    halt();
    play = 1'b1; stop = 1'b1; step();
    play = 1'b0; stop = 1'b0; step();
    chk("ps_busy", busy, 0);

    // reset mid-PINGPONG with slow_clk held high through release
    start(2'b01, 4'd1, 4'd3, 4'd0);
    tick(); tick();
    chk("rp_idx", frame_idx, 3);
    slow_clk = 1'b1;
    rst = 1'b1; step();
    chk("rp_idx0", frame_idx, 0);
    chk("rp_base0", frame_base, 0);
    chk("rp_busy0", busy, 0);
    chk("rp_done0", done, 0);
    rst = 1'b0;
    start(2'b00, 4'd4, 4'd6, 4'd0);
    step(); step(); step();
    chk("rr_notick", frame_idx, 4);
    slow_clk = 1'b0; step();
    slow_clk = 1'b1; step(); step();
    chk("rr_tick", frame_idx, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
